// File: rtl/rf_wb_pkg.sv
// rtl/rf_wb_pkg.sv - shared widths, write-buffer entry type and constants
// for the register-file writeback arbiter.
package rf_wb_pkg;

  localparam int RF_AW = 5;
  localparam int RF_DW = 32;

  typedef struct packed {
    logic [RF_AW-1:0] ad;
    logic [RF_DW-1:0] wd;
  } wb_entry_t;

  localparam logic [RF_AW-1:0] REG_ZERO = '0;

endpackage

// File: rtl/rf_wb_fifo.sv
// rtl/rf_wb_fifo.sv - in-order write buffer for multi-cycle results;
// head is valid whenever empty is low.
module rf_wb_fifo
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      push,
  input  wb_entry_t din,
  input  logic      pop,
  output logic      full,
  output logic      empty,
  output wb_entry_t head
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  wb_entry_t         mem_q [DEPTH];
  wb_entry_t         mem_d [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = ptr_next(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_next(rd_ptr_q);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - register-file write-port arbiter with busy scoreboard;
// RF_WB_BYPASS_EN enables zero-latency direct writes of mc results when idle.
module rf_wb_arbiter
  import rf_wb_pkg::*;
#(
  parameter int ADDRESS_WIDTH = RF_AW,
  parameter int DATA_WIDTH    = RF_DW,
  parameter int BUF_DEPTH     = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     pipe_we,
  input  logic [ADDRESS_WIDTH-1:0] pipe_ad,
  input  logic [DATA_WIDTH-1:0]    pipe_wd,
  input  logic                     mc_valid,
  input  logic [ADDRESS_WIDTH-1:0] mc_ad,
  input  logic [DATA_WIDTH-1:0]    mc_wd,
  output logic                     mc_ready,
  input  logic                     iss_valid,
  input  logic [ADDRESS_WIDTH-1:0] iss_rd,
  input  logic [ADDRESS_WIDTH-1:0] rs1,
  input  logic [ADDRESS_WIDTH-1:0] rs2,
  input  logic [ADDRESS_WIDTH-1:0] rd_q,
  output logic                     busy_rs1,
  output logic                     busy_rs2,
  output logic                     busy_rd,
  output logic                     WE3,
  output logic [ADDRESS_WIDTH-1:0] AD3,
  output logic [DATA_WIDTH-1:0]    WD3
);

  localparam int NREG = 2 ** ADDRESS_WIDTH;

  logic [NREG-1:0]          busy_q, busy_d;
  logic                     fifo_full, fifo_empty;
  wb_entry_t                fifo_head;
  wb_entry_t                fifo_din;
  logic                     push, pop, bypass;
  logic                     commit_mc;
  logic [ADDRESS_WIDTH-1:0] commit_ad;

  assign mc_ready = !rst && !fifo_full;
  assign fifo_din = '{ad: mc_ad, wd: mc_wd};

`ifdef RF_WB_BYPASS_EN
  assign bypass = !rst && !pipe_we && fifo_empty && mc_valid;
`else
  assign bypass = 1'b0;
`endif

  assign push = mc_valid && mc_ready && !bypass;
  assign pop  = !rst && !pipe_we && !fifo_empty;

  // Buffered results retire either by popping the head or by the bypass path.
  always_comb begin
    commit_mc = 1'b0;
    commit_ad = '0;
    WE3       = 1'b0;
    AD3       = '0;
    WD3       = '0;
    if (!rst) begin
      if (pipe_we) begin
        WE3 = (pipe_ad != REG_ZERO);
        AD3 = pipe_ad;
        WD3 = pipe_wd;
      end else if (!fifo_empty) begin
        commit_mc = 1'b1;
        commit_ad = fifo_head.ad;
        WE3       = (fifo_head.ad != REG_ZERO);
        AD3       = fifo_head.ad;
        WD3       = fifo_head.wd;
      end else if (bypass) begin
        commit_mc = 1'b1;
        commit_ad = mc_ad;
        WE3       = (mc_ad != REG_ZERO);
        AD3       = mc_ad;
        WD3       = mc_wd;
      end
    end
  end

  // Clear first so that a same-edge issue to the retiring register keeps it busy.
  always_comb begin
    busy_d = busy_q;
    if (commit_mc) begin
      busy_d[commit_ad] = 1'b0;
    end
    if (iss_valid) begin
      busy_d[iss_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_rs1 = busy_q[rs1];
  assign busy_rs2 = busy_q[rs2];
  assign busy_rd  = busy_q[rd_q];

  rf_wb_fifo #(
    .DEPTH (BUF_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (fifo_din),
    .pop   (pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (fifo_head)
  );

  a_iss_not_busy : assert property (@(posedge clk) disable iff (rst)
    !(iss_valid && busy_q[iss_rd] && !(commit_mc && commit_ad == iss_rd)));

  a_pipe_not_busy : assert property (@(posedge clk) disable iff (rst)
    !(pipe_we && pipe_ad != REG_ZERO && busy_q[pipe_ad]));

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - directed self-checking bench for rf_wb_arbiter.
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        pipe_we;
  logic [4:0]  pipe_ad;
  logic [31:0] pipe_wd;
  logic        mc_valid;
  logic [4:0]  mc_ad;
  logic [31:0] mc_wd;
  logic        mc_ready;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic [4:0]  rs1, rs2, rd_q;
  logic        busy_rs1, busy_rs2, busy_rd;
  logic        WE3;
  logic [4:0]  AD3;
  logic [31:0] WD3;

  int n_cmp = 0;
  int n_bad = 0;

`ifdef RF_WB_BYPASS_EN
  localparam int LAT = 0;
`else
  localparam int LAT = 1;
`endif

  rf_wb_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .pipe_we  (pipe_we),
    .pipe_ad  (pipe_ad),
    .pipe_wd  (pipe_wd),
    .mc_valid (mc_valid),
    .mc_ad    (mc_ad),
    .mc_wd    (mc_wd),
    .mc_ready (mc_ready),
    .iss_valid(iss_valid),
    .iss_rd   (iss_rd),
    .rs1      (rs1),
    .rs2      (rs2),
    .rd_q     (rd_q),
    .busy_rs1 (busy_rs1),
    .busy_rs2 (busy_rs2),
    .busy_rd  (busy_rd),
    .WE3      (WE3),
    .AD3      (AD3),
    .WD3      (WD3)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    pipe_we   = 1'b0; pipe_ad = '0; pipe_wd = '0;
    mc_valid  = 1'b0; mc_ad   = '0; mc_wd   = '0;
    iss_valid = 1'b0; iss_rd  = '0;
  endtask

  initial begin
    idle();
    rs1 = '0; rs2 = '0; rd_q = '0;
    rst = 1'b1;
    tick(); tick();
    check("rst_we3", WE3, 0);
    check("rst_mc_ready", mc_ready, 0);
    check("rst_ad3", AD3, 0);
    check("rst_wd3", WD3, 0);
    rst = 1'b0;
    #1;
    check("post_rst_mc_ready", mc_ready, 1);

    // scoreboard set, commit, clear
    rs1 = 5'd5;
    iss_valid = 1'b1; iss_rd = 5'd5;
    #1 check("t2_busy_pre_issue", busy_rs1, 0);
    tick();
    idle();
    check("t2_busy_after_issue", busy_rs1, 1);
    mc_valid = 1'b1; mc_ad = 5'd5; mc_wd = 32'hDEAD_BEEF;
    #1 check("t2_mc_ready", mc_ready, 1);
    if (LAT == 0) begin
      check("t2_byp_we3", WE3, 1);
      check("t2_byp_ad3", AD3, 5);
      check("t2_byp_wd3", WD3, 32'hDEAD_BEEF);
      check("t2_byp_busy", busy_rs1, 1);
      tick();
      idle();
    end else begin
      check("t2_we3_push_cycle", WE3, 0);
      tick();
      idle();
      #1;
      check("t2_we3", WE3, 1);
      check("t2_ad3", AD3, 5);
      check("t2_wd3", WD3, 32'hDEAD_BEEF);
      check("t2_busy_commit_cycle", busy_rs1, 1);
      tick();
    end
    check("t2_we3_after", WE3, 0);
    check("t2_busy_cleared", busy_rs1, 0);

    // contention: pipeline owns the port while mc fills the buffer
    iss_valid = 1'b1; iss_rd = 5'd6; tick();
    iss_rd = 5'd7; tick();
    idle();
    for (int k = 1; k <= 4; k++) begin
      pipe_we = 1'b1; pipe_ad = 5'(k); pipe_wd = 32'h10 + 32'(k);
      mc_valid = (k <= 2);
      mc_ad = (k == 1) ? 5'd6 : 5'd7;
      mc_wd = (k == 1) ? 32'h66 : 32'h77;
      #1;
      check($sformatf("t3_pipe_we3_%0d", k), WE3, 1);
      check($sformatf("t3_pipe_ad3_%0d", k), AD3, k);
      check($sformatf("t3_pipe_wd3_%0d", k), WD3, 32'h10 + 32'(k));
      check($sformatf("t3_mc_ready_%0d", k), mc_ready, (k <= 2) ? 1 : 0);
      tick();
    end
    idle();
    rs1 = 5'd6; rs2 = 5'd7;
    #1;
    check("t3_drain0_we3", WE3, 1);
    check("t3_drain0_ad3", AD3, 6);
    check("t3_drain0_wd3", WD3, 32'h66);
    check("t3_drain0_ready", mc_ready, 0);
    tick();
    check("t3_drain1_ad3", AD3, 7);
    check("t3_drain1_wd3", WD3, 32'h77);
    check("t3_drain1_ready", mc_ready, 1);
    check("t3_busy6", busy_rs1, 0);
    check("t3_busy7", busy_rs2, 1);
    tick();
    check("t3_drained_we3", WE3, 0);
    check("t3_busy7_clear", busy_rs2, 0);

    // x0 writes never reach the register file
    pipe_we = 1'b1; pipe_ad = 5'd0; pipe_wd = 32'h1;
    mc_valid = 1'b1; mc_ad = 5'd0; mc_wd = 32'h2;
    #1 check("t4_pipe_x0_we3", WE3, 0);
    tick();
    idle();
    #1 check("t4_fifo_x0_we3", WE3, 0);
    tick();
    mc_valid = 1'b1; mc_ad = 5'd8; mc_wd = 32'h88;
    #1;
    check("t4_ready", mc_ready, 1);
    check("t4_x8_first_we3", WE3, (LAT == 0) ? 1 : 0);
    tick();
    idle();
    #1 check("t4_x8_second_we3", WE3, (LAT == 0) ? 0 : 1);
    check("t4_x8_second_ad3", AD3, (LAT == 0) ? 0 : 8);
    tick();

    // same-edge retire and reissue of x9
    rd_q = 5'd9;
    iss_valid = 1'b1; iss_rd = 5'd9; tick();
    idle();
    mc_valid = 1'b1; mc_ad = 5'd9; mc_wd = 32'h99;
    if (LAT == 1) begin
      tick();
      idle();
    end
    iss_valid = 1'b1; iss_rd = 5'd9;
    #1;
    check("t5_we3", WE3, 1);
    check("t5_ad3", AD3, 9);
    tick();
    idle();
    check("t5_busy_kept", busy_rd, 1);
    mc_valid = 1'b1; mc_ad = 5'd9; mc_wd = 32'h9A;
    tick();
    idle();
    tick();
    check("t5_busy_final", busy_rd, 0);

    // pointer wrap with back-to-back results
    for (int k = 0; k <= 5; k++) begin
      mc_valid = (k < 5); mc_ad = 5'(10 + k); mc_wd = 32'hA0 + 32'(k);
      #1;
      if (k - LAT >= 0 && k - LAT < 5) begin
        check($sformatf("t6_we3_%0d", k), WE3, 1);
        check($sformatf("t6_ad3_%0d", k), AD3, 10 + k - LAT);
        check($sformatf("t6_wd3_%0d", k), WD3, 32'hA0 + 32'(k - LAT));
      end else begin
        check($sformatf("t6_idle_%0d", k), WE3, 0);
      end
      if (k < 5) check($sformatf("t6_ready_%0d", k), mc_ready, 1);
      tick();
    end
    idle();

    // reset with two entries buffered and one busy register
    rs1 = 5'd14;
    iss_valid = 1'b1; iss_rd = 5'd14; tick();
    idle();
    pipe_we = 1'b1; pipe_ad = 5'd1; pipe_wd = 32'h1;
    mc_valid = 1'b1; mc_ad = 5'd12; mc_wd = 32'hC;
    tick();
    pipe_ad = 5'd2; mc_ad = 5'd13; mc_wd = 32'hD;
    tick();
    mc_valid = 1'b0;
    #1;
    check("t1_full_ready", mc_ready, 0);
    check("t1_busy_pre", busy_rs1, 1);
    pipe_we = 1'b0;
    rst = 1'b1;
    #1;
    check("t1_rst_we3", WE3, 0);
    check("t1_rst_ready", mc_ready, 0);
    check("t1_rst_ad3", AD3, 0);
    check("t1_rst_busy", busy_rs1, 0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1 check($sformatf("t1_no_write_%0d", k), WE3, 0);
      tick();
    end
    check("t1_ready_after", mc_ready, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
